ysyx_24090003_lsu_axil_bridge: RTL and testbench

- Sits directly downstream of the LSU; consumes its memory request (addr, wdata, we, en, wmask) and issues it as a single AXI4-Lite transaction to the data-side bus/xbar.
- Performs byte-lane placement for writes (wstrb and wdata shifted by addr[1:0]).
- Right-aligns read data so the LSU's sign/zero extension on bits [7:0]/[15:0] is correct.
- Provides a valid/ready request handshake and a one-cycle response pulse that the core uses to stall the memory stage.

---
 rtl/ysyx_24090003_lsu_axil_bridge.sv | 186 ++++++++++++++++++
 tb/tb_ysyx_24090003_lsu_axil_bridge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24090003_lsu_axil_bridge.sv
// ysyx_24090003_lsu_axil_bridge: turns one LSU memory request into one AXI4-Lite transaction
//
// Ports:
//   clk, rst                         clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready              LSU request handshake
//   req_addr/req_wdata/req_we/req_wmask  request payload (wmask 001 byte, 010 half, 100 word)
//   resp_valid/resp_rdata/resp_err   one-cycle completion pulse, right-aligned load data, fault flag
//   aw*/w*/b*/ar*/r*                 AXI4-Lite master channels, all outputs registered
//
// Optional build macro:
//   YSYX_24090003_LSU_MISALIGN_CHECK_EN  misaligned half/word requests skip the bus and
//                                        complete immediately with resp_err=1
module ysyx_24090003_lsu_axil_bridge #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic                  req_we,
    input  logic [2:0]            req_wmask,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

    state_t                state, state_n;
    logic [1:0]            off, off_n;
    logic                  misalign, aw_left, w_left, wr_done;
    logic [DATA_W/8-1:0]   base;
    logic                  awvalid_n, wvalid_n, arvalid_n, bready_n, rready_n;
    logic                  req_ready_n, resp_valid_n, err_n;
    logic [ADDR_W-1:0]     awaddr_n, araddr_n;
    logic [DATA_W-1:0]     wdata_n, rdata_n;
    logic [DATA_W/8-1:0]   wstrb_n;

`ifdef YSYX_24090003_LSU_MISALIGN_CHECK_EN
    assign misalign = (req_wmask == 3'b001) ? 1'b0 :
                      (req_wmask == 3'b010) ? req_addr[0] : (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Unknown masks fall back to a full word.
    assign base    = (req_wmask == 3'b001) ? 4'b0001 : (req_wmask == 3'b010) ? 4'b0011 : 4'b1111;
    // AW and W retire independently; the write phase ends once neither is still pending.
    assign aw_left = awvalid & ~awready;
    assign w_left  = wvalid & ~wready;
    assign wr_done = ~aw_left & ~w_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = !req_valid ? IDLE : misalign ? RESP : req_we ? WR_REQ : RD_REQ;
            WR_REQ:  state_n = wr_done ? WR_RESP : WR_REQ;
            WR_RESP: state_n = bvalid ? RESP : WR_RESP;
            RD_REQ:  state_n = arready ? RD_DATA : RD_REQ;
            RD_DATA: state_n = rvalid ? RESP : RD_DATA;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        awvalid_n = awvalid;
        wvalid_n  = wvalid;
        arvalid_n = arvalid;
        bready_n  = bready;
        rready_n  = rready;
        awaddr_n  = awaddr;
        araddr_n  = araddr;
        wdata_n   = wdata;
        wstrb_n   = wstrb;
        off_n     = off;
        rdata_n   = resp_rdata;
        err_n     = resp_err;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    off_n = req_addr[1:0];
                    err_n = misalign;
                    if (!misalign && req_we) begin
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        awaddr_n  = req_addr;
                        wstrb_n   = base << req_addr[1:0];
                        wdata_n   = req_wdata << {req_addr[1:0], 3'b000};
                    end
                    if (!misalign && !req_we) begin
                        arvalid_n = 1'b1;
                        araddr_n  = req_addr;
                    end
                end
            end
            WR_REQ: begin
                awvalid_n = aw_left;
                wvalid_n  = w_left;
                bready_n  = wr_done;
            end
            WR_RESP: begin
                if (bvalid) begin
                    bready_n = 1'b0;
                    err_n    = |bresp;
                end
            end
            RD_REQ: begin
                if (arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                end
            end
            RD_DATA: begin
                if (rvalid) begin
                    rready_n = 1'b0;
                    rdata_n  = rdata >> {off, 3'b000};
                    err_n    = |rresp;
                end
            end
            default: ;
        endcase
    end

    // Handshake flags follow the next state so they line up with it cycle-for-cycle.
    assign req_ready_n  = (state_n == IDLE);
    assign resp_valid_n = (state_n == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            arvalid    <= 1'b0;
            bready     <= 1'b0;
            rready     <= 1'b0;
            awaddr     <= '0;
            araddr     <= '0;
            wdata      <= '0;
            wstrb      <= '0;
            off        <= 2'b00;
        end else begin
            req_ready  <= req_ready_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= rdata_n;
            resp_err   <= err_n;
            awvalid    <= awvalid_n;
            wvalid     <= wvalid_n;
            arvalid    <= arvalid_n;
            bready     <= bready_n;
            rready     <= rready_n;
            awaddr     <= awaddr_n;
            araddr     <= araddr_n;
            wdata      <= wdata_n;
            wstrb      <= wstrb_n;
            off        <= off_n;
        end
    end
endmodule

// File: tb/tb_ysyx_24090003_lsu_axil_bridge.sv
// tb_ysyx_24090003_lsu_axil_bridge: scoreboard bench with a small AXI4-Lite slave model
module tb_ysyx_24090003_lsu_axil_bridge;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_wmask = 3'b100;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    ysyx_24090003_lsu_axil_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_we(req_we), .req_wmask(req_wmask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, acc_cyc = 0, resp_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Slave model: configurable AW stall, immediate W/AR, B one cycle after both
    // write channels complete, R data r_lat cycles after the AR handshake.
    int          aw_wait = 0, r_lat = 1, aw_cnt, rc, bcount, arcount;
    logic        aw_got, w_got, rpend;
    logic [31:0] slave_rdata = '0;
    logic [1:0]  slave_bresp = '0, slave_rresp = '0;
    wire         hs_aw = awvalid && awready;
    wire         hs_w  = wvalid && wready;

    assign awready = (aw_cnt >= aw_wait);
    assign wready  = 1'b1;
    assign arready = 1'b1;
    assign rdata   = slave_rdata;
    assign rresp   = slave_rresp;
    assign bresp   = slave_bresp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b0;
            rpend <= 1'b0; rc <= 0; rvalid <= 1'b0;
        end else begin
            aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
            if (bvalid && bready) begin
                bvalid <= 1'b0;
                bcount <= bcount + 1;
            end else if ((aw_got || hs_aw) && (w_got || hs_w)) begin
                bvalid <= 1'b1;
                aw_got <= 1'b0;
                w_got  <= 1'b0;
            end else begin
                if (hs_aw) aw_got <= 1'b1;
                if (hs_w)  w_got  <= 1'b1;
            end
            if (arvalid && arready) begin
                rpend   <= 1'b1;
                rc      <= 1;
                arcount <= arcount + 1;
            end else if (rpend) begin
                if (rc >= r_lat) begin
                    rvalid <= 1'b1;
                    rpend  <= 1'b0;
                end else rc <= rc + 1;
            end
            if (rvalid && rready) rvalid <= 1'b0;
        end
    end

    initial begin
        bcount = 0;
        arcount = 0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [31:0] rd; logic err; int lat;} exp_t;
    exp_t        resp_q[$];
    logic [31:0] aw_q[$], w_q[$], ar_q[$];
    logic [3:0]  s_q[$];

    // Monitor: compares every bus handshake and every response pulse against the queues.
    always @(negedge clk) begin
        if (hs_aw) begin
            if (aw_q.size() == 0) chk("unexpected_aw", awaddr, 32'hxxxxxxxx);
            else chk("awaddr", awaddr, aw_q.pop_front());
        end
        if (hs_w) begin
            if (w_q.size() == 0) chk("unexpected_w", wdata, 32'hxxxxxxxx);
            else begin
                chk("wdata", wdata, w_q.pop_front());
                chk("wstrb", {28'h0, wstrb}, {28'h0, s_q.pop_front()});
            end
        end
        if (arvalid && arready) begin
            if (ar_q.size() == 0) chk("unexpected_ar", araddr, 32'hxxxxxxxx);
            else chk("araddr", araddr, ar_q.pop_front());
        end
        if (resp_valid) begin
            if (resp_q.size() == 0) chk("unexpected_resp", resp_rdata, 32'hxxxxxxxx);
            else begin
                exp_t e;
                e = resp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rd);
                chk("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                chk("latency", cyc - acc_cyc, e.lat);
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic w,
                         input logic [2:0] m, input logic [31:0] ew, input logic [3:0] es,
                         input logic [31:0] er, input logic ee, input int el,
                         input bit bus, input bit resp);
        bit done = 0;
        if (bus && w) begin
            aw_q.push_back(a);
            w_q.push_back(ew);
            s_q.push_back(es);
        end
        if (bus && !w) ar_q.push_back(a);
        if (resp) resp_q.push_back('{er, ee, el});
        @(posedge clk);
        #1;
        req_valid = 1'b1; req_addr = a; req_wdata = wd; req_we = w; req_wmask = m;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (req_ready) begin
                acc_cyc = cyc;
                done = 1;
            end
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        bit done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                resp_cyc = cyc;
                done = 1;
            end
        end
        if (!done) chk(name, 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int b0, a0;
        bit got;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
        chk("rst_valids", {26'h0, resp_valid, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addrs", awaddr | araddr | wdata | {28'h0, wstrb} | {31'h0, resp_err}, 32'd0);

        // store byte at offset 3
        issue(32'h80000003, 32'h000000AB, 1, 3'b001, 32'hAB000000, 4'b1000, 32'h0, 0, 3, 1, 1);
        wait_resp("resp_timeout_sb");

        // load half at offset 2
        slave_rdata = 32'h1234ABCD;
        issue(32'h80000002, 0, 0, 3'b010, 0, 0, 32'h00001234, 0, 4, 1, 1);
        wait_resp("resp_timeout_lh");

        // write-channel skew: AW stalled 3 cycles, W immediate
        aw_wait = 3;
        b0 = bcount;
        issue(32'h80000010, 32'h01020304, 1, 3'b100, 32'h01020304, 4'b1111, 32'h00001234, 0, 6, 1, 1);
        @(negedge clk);
        chk("skew_c1", {30'h0, awvalid, wvalid}, 32'd3);
        @(negedge clk);
        chk("skew_c2", {30'h0, awvalid, wvalid}, 32'd2);
        wait_resp("resp_timeout_skew");
        aw_wait = 0;
        @(negedge clk);
        chk("skew_bcount", bcount - b0, 32'd1);

        // read error, then a store accepted on the very next cycle (with its own bus error)
        slave_rdata = 32'hDEADBEEF;
        slave_rresp = 2'b10;
        issue(32'h80000020, 0, 0, 3'b100, 0, 0, 32'hDEADBEEF, 1, 4, 1, 1);
        wait_resp("resp_timeout_rerr");
        slave_rresp = 2'b00;
        slave_bresp = 2'b10;
        issue(32'h80000006, 32'h00005678, 1, 3'b010, 32'h56780000, 4'b1100, 32'hDEADBEEF, 1, 3, 1, 1);
        chk("accept_after_err", acc_cyc - resp_cyc, 32'd1);
        wait_resp("resp_timeout_herr");
        slave_bresp = 2'b00;

        // load byte at offset 1
        slave_rdata = 32'h11223344;
        issue(32'h80000001, 0, 0, 3'b001, 0, 0, 32'h00112233, 0, 4, 1, 1);
        wait_resp("resp_timeout_lb");

`ifdef YSYX_24090003_LSU_MISALIGN_CHECK_EN
        a0 = arcount;
        issue(32'h80000001, 0, 0, 3'b100, 0, 0, 32'h00112233, 1, 1, 0, 1);
        wait_resp("resp_timeout_mis");
        @(negedge clk);
        chk("mis_no_ar", arcount, a0);
`else
        a0 = arcount;
        // half at offset 3: upper lane dropped
        issue(32'h80000003, 32'h0000BEEF, 1, 3'b010, 32'hEF000000, 4'b1000, 32'h00112233, 0, 3, 1, 1);
        wait_resp("resp_timeout_trunc");
        @(negedge clk);
        chk("trunc_no_ar", arcount, a0);
`endif

        // reset while waiting for read data
        r_lat = 20;
        slave_rdata = 32'h55555555;
        issue(32'h80000040, 0, 0, 3'b100, 0, 0, 0, 0, 0, 1, 0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rready;
        end
        chk("mid_rready", {31'h0, got}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valids", {27'h0, awvalid, wvalid, arvalid, bready, rready}, 32'd0);
        chk("mid_rst_resp", {31'h0, resp_valid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        r_lat = 1;
        repeat (5) @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'd1);
        chk("post_rst_rdata", resp_rdata, 32'd0);

        // normal word load after reset
        slave_rdata = 32'hCAFEF00D;
        issue(32'h80000000, 0, 0, 3'b100, 0, 0, 32'hCAFEF00D, 0, 4, 1, 1);
        wait_resp("resp_timeout_lw");

        repeat (3) @(negedge clk);
        chk("resp_q_empty", resp_q.size(), 32'd0);
        chk("bus_q_empty", aw_q.size() + w_q.size() + ar_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
